clocks_4004_gen: RTL and testbench

Parametrised successor to the fixed 4004 clock block: from the single emulation clock it generates the non-overlapping two-phase clocks `clk1`/`clk2` and the chip `reset` for 4004-family netlist cores.
- Period, phase widths, gaps and reset hold length are parameters.
- Adds a machine-subcycle counter (0–7) and a period strobe for bench alignment.
- Optionally adds run/halt/single-step control.
- Instantiated in test SoCs in place of the fixed block, driving `chip_4004` and peripheral models.

---
 rtl/clocks_4004_gen.sv | 184 ++++++++++++++++++
 tb/tb_clocks_4004_gen.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clocks_4004_gen.sv
// clocks_4004_gen: two-phase non-overlapping clock, chip reset and subcycle generator for 4004 cores.
// Latency: every output is registered; the first cycle after ereset_n is sampled high has p = 0.
// Backpressure: none; with CLOCKS_4004_STEP_EN defined, run/step can halt or single-step the generator.
module clocks_4004_gen #(
  parameter int PERIOD        = 20,
  parameter int CLK1_W        = 6,
  parameter int CLK2_W        = 6,
  parameter int GAP           = 2,
  parameter int RESET_PERIODS = 16
) (
  input  logic       eclk,
  input  logic       ereset_n,
  input  logic       run,
  input  logic       step,
  output logic       reset,
  output logic       clk1,
  output logic       clk2,
  output logic       period_start,
  output logic [2:0] subcyc,
  output logic       halted
);

  // Phase decode boundaries, all in the 8-bit phase counter domain.
  localparam logic [7:0] P_LAST = 8'(PERIOD - 1);
  localparam logic [7:0] C1_END = 8'(CLK1_W);
  localparam logic [7:0] C2_BEG = 8'(CLK1_W + GAP);
  localparam logic [7:0] C2_END = 8'(CLK1_W + GAP + CLK2_W);

  // Reset countdown counts period starts already seen while reset is high.
  localparam int             RCW      = (RESET_PERIODS > 1) ? $clog2(RESET_PERIODS) : 1;
  localparam logic [RCW-1:0] RST_LAST = RCW'(RESET_PERIODS - 1);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2,
    S_STEP  = 2'd3
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic           go;          // the next cycle is an active (clocking) cycle
  logic           at_last;     // current cycle is p = PERIOD-1
  logic           new_per;     // the next cycle is p = 0 of a new period
  logic [7:0]     p_q;
  logic [7:0]     p_nxt;
  logic [RCW-1:0] rst_cnt;
  logic [RCW-1:0] rst_cnt_nxt;
  logic           reset_nxt;
  logic           clk1_nxt;
  logic           clk2_nxt;
  logic           ps_nxt;
  logic [2:0]     subcyc_nxt;

  // State register; ereset_n low forces RESET on the next edge.
  always_ff @(posedge eclk) begin
    if (!ereset_n) begin
      state <= S_RESET;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and the "advance the phase counter" decision.
  always_comb begin
    state_nxt = state;
    go        = 1'b1;
    at_last   = (p_q == P_LAST);
    case (state)
      S_RESET: begin
        state_nxt = S_RUN;
      end
      S_RUN: begin
`ifdef CLOCKS_4004_STEP_EN
        // Halting only happens at a period boundary and never during chip reset.
        if (at_last && !reset && !run) begin
          state_nxt = S_HALT;
          go        = 1'b0;
        end
`endif
      end
`ifdef CLOCKS_4004_STEP_EN
      S_HALT: begin
        // run wins over step when both are seen together.
        if (run) begin
          state_nxt = S_RUN;
        end else if (step) begin
          state_nxt = S_STEP;
        end else begin
          go = 1'b0;
        end
      end
      S_STEP: begin
        // step pulses are ignored here; only run at the period end matters.
        if (at_last) begin
          if (run) begin
            state_nxt = S_RUN;
          end else begin
            state_nxt = S_HALT;
            go        = 1'b0;
          end
        end
      end
`endif
      default: begin
        state_nxt = S_RESET;
      end
    endcase
  end

  // Phase counter advance, phase decodes, reset countdown and subcycle index.
  always_comb begin
    p_nxt       = p_q;
    reset_nxt   = reset;
    rst_cnt_nxt = rst_cnt;
    subcyc_nxt  = subcyc;
    if (go) begin
      p_nxt = at_last ? 8'd0 : (p_q + 8'd1);
    end
    new_per  = go && (p_nxt == 8'd0);
    clk1_nxt = go && (p_nxt < C1_END);
    clk2_nxt = go && (p_nxt >= C2_BEG) && (p_nxt < C2_END);
    ps_nxt   = new_per;
    if (state == S_RESET) begin
      // Leaving RESET starts period 0 of the chip reset hold.
      reset_nxt   = 1'b1;
      rst_cnt_nxt = '0;
      subcyc_nxt  = 3'd0;
    end else if (new_per) begin
      if (reset) begin
        // subcyc stays 0 through the period in which reset drops.
        subcyc_nxt = 3'd0;
        if (rst_cnt == RST_LAST) begin
          reset_nxt = 1'b0;
        end else begin
          rst_cnt_nxt = rst_cnt + 1'b1;
        end
      end else begin
        subcyc_nxt = subcyc + 3'd1;
      end
    end
  end

  // Output and counter registers; p is parked at PERIOD-1 so the first active cycle is p = 0.
  always_ff @(posedge eclk) begin
    if (!ereset_n) begin
      p_q          <= P_LAST;
      rst_cnt      <= '0;
      reset        <= 1'b1;
      clk1         <= 1'b0;
      clk2         <= 1'b0;
      period_start <= 1'b0;
      subcyc       <= 3'd0;
    end else begin
      p_q          <= p_nxt;
      rst_cnt      <= rst_cnt_nxt;
      reset        <= reset_nxt;
      clk1         <= clk1_nxt;
      clk2         <= clk2_nxt;
      period_start <= ps_nxt;
      subcyc       <= subcyc_nxt;
    end
  end

`ifdef CLOCKS_4004_STEP_EN
  // halted is high exactly while the generator sits in HALT.
  always_ff @(posedge eclk) begin
    if (!ereset_n) begin
      halted <= 1'b0;
    end else begin
      halted <= (state_nxt == S_HALT);
    end
  end
`else
  // Without run/step control the generator never halts and the inputs are dropped.
  logic unused_ctrl;
  assign unused_ctrl = run ^ step;
  assign halted      = 1'b0;
`endif

  // The two phases must never be high together.
  assert property (@(posedge eclk) disable iff (!ereset_n) !(clk1 && clk2));

endmodule

// File: tb/tb_clocks_4004_gen.sv
module tb_clocks_4004_gen;

`ifdef CLOCKS_4004_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic eclk;
  logic ereset_n;
  logic run;
  logic step;

  logic       reset_a, clk1_a, clk2_a, ps_a, halted_a;
  logic [2:0] subcyc_a;
  logic       reset_b, clk1_b, clk2_b, ps_b, halted_b;
  logic [2:0] subcyc_b;

  logic [7:0] obs_a;
  logic [7:0] obs_b;
  assign obs_a = {reset_a, clk1_a, clk2_a, ps_a, subcyc_a, halted_a};
  assign obs_b = {reset_b, clk1_b, clk2_b, ps_b, subcyc_b, halted_b};

  int errors = 0;
  int checks = 0;

  clocks_4004_gen dut_a (
    .eclk(eclk), .ereset_n(ereset_n), .run(run), .step(step),
    .reset(reset_a), .clk1(clk1_a), .clk2(clk2_a), .period_start(ps_a),
    .subcyc(subcyc_a), .halted(halted_a)
  );

  clocks_4004_gen #(
    .PERIOD(8), .CLK1_W(2), .CLK2_W(2), .GAP(1), .RESET_PERIODS(1)
  ) dut_b (
    .eclk(eclk), .ereset_n(ereset_n), .run(run), .step(step),
    .reset(reset_b), .clk1(clk1_b), .clk2(clk2_b), .period_start(ps_b),
    .subcyc(subcyc_b), .halted(halted_b)
  );

  initial eclk = 1'b0;
  always #5 eclk = ~eclk;

  // Reference model: per instance, the count of active cycles since release.
  // Everything observable follows from that count and the parameters.
  int mp[2]  = '{20, 8};
  int mc1[2] = '{6, 2};
  int mc2[2] = '{6, 2};
  int mg[2]  = '{2, 1};
  int mrp[2] = '{16, 1};
  bit m_inrst[2] = '{1'b1, 1'b1};
  bit m_halt[2]  = '{1'b0, 1'b0};
  int m_n[2]     = '{0, 0};

  task automatic model_adv(input int k, input logic ern, input logic rn, input logic st);
    if (!ern) begin
      m_inrst[k] = 1'b1;
      m_halt[k]  = 1'b0;
      m_n[k]     = 0;
    end else if (m_inrst[k]) begin
      m_inrst[k] = 1'b0;
      m_n[k]     = 0;
    end else if (m_halt[k]) begin
      if (STEP_EN && (rn || st)) begin
        m_halt[k] = 1'b0;
        m_n[k]    = m_n[k] + 1;
      end
    end else if (STEP_EN && !rn && (m_n[k] % mp[k] == mp[k] - 1) && (m_n[k] / mp[k] >= mrp[k])) begin
      m_halt[k] = 1'b1;
    end else begin
      m_n[k] = m_n[k] + 1;
    end
  endtask

  // Expected {reset, clk1, clk2, period_start, subcyc, halted}.
  function automatic logic [7:0] exp_out(input int k);
    int p;
    int idx;
    logic r;
    logic [2:0] sc;
    if (m_inrst[k]) return 8'b1000_0000;
    p   = m_n[k] % mp[k];
    idx = m_n[k] / mp[k];
    r   = (idx < mrp[k]);
    sc  = r ? 3'd0 : 3'((idx - mrp[k]) % 8);
    if (m_halt[k]) return {4'b0000, sc, 1'b1};
    return {r, (p < mc1[k]), ((p >= mc1[k] + mg[k]) && (p < mc1[k] + mg[k] + mc2[k])), (p == 0), sc, 1'b0};
  endfunction

  // One eclk edge: the model sees the same inputs the DUTs sample, outputs read 1 ns later.
  task automatic tick();
    @(posedge eclk);
    model_adv(0, ereset_n, run, step);
    model_adv(1, ereset_n, run, step);
    #1;
  endtask

  task automatic test_reset();
    ereset_n = 1'b0;
    run      = 1'b1;
    step     = 1'b0;
    repeat (3) tick();
    checks++;
    if (obs_a !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset_values_a: got %b expected %b", obs_a, 8'b1000_0000);
    end
    checks++;
    if (obs_b !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset_values_b: got %b expected %b", obs_b, 8'b1000_0000);
    end
    ereset_n = 1'b1;
    tick();
    checks++;
    if (obs_a !== 8'b1101_0000) begin
      errors++;
      $display("FAIL first_cycle_a: got %b expected %b", obs_a, 8'b1101_0000);
    end
    checks++;
    if (obs_b !== 8'b1101_0000) begin
      errors++;
      $display("FAIL first_cycle_b: got %b expected %b", obs_b, 8'b1101_0000);
    end
  endtask

  // 1000 periods of the default instance with run high and random step pulses.
  task automatic test_free_run();
    bit fell_a = 1'b0;
    bit fell_b = 1'b0;
    run = 1'b1;
    for (int i = 1; i <= 20000; i++) begin
      step = ($urandom_range(0, 5) == 0);
      tick();
      checks++;
      if (obs_a !== exp_out(0)) begin
        errors++;
        $display("FAIL free_run_a cycle %0d: got %b expected %b", i, obs_a, exp_out(0));
      end
      checks++;
      if (obs_b !== exp_out(1)) begin
        errors++;
        $display("FAIL free_run_b cycle %0d: got %b expected %b", i, obs_b, exp_out(1));
      end
      checks++;
      if ((clk1_a & clk2_a) !== 1'b0 || (clk1_b & clk2_b) !== 1'b0) begin
        errors++;
        $display("FAIL overlap cycle %0d: a=%b%b b=%b%b expected no overlap", i, clk1_a, clk2_a, clk1_b, clk2_b);
      end
      if (!fell_a && reset_a === 1'b0) begin
        fell_a = 1'b1;
        checks++;
        if (i != 320) begin
          errors++;
          $display("FAIL reset_fall_a: fell at cycle %0d expected 320", i);
        end
      end
      if (!fell_b && reset_b === 1'b0) begin
        fell_b = 1'b1;
        checks++;
        if (i != 8) begin
          errors++;
          $display("FAIL reset_fall_b: fell at cycle %0d expected 8", i);
        end
      end
    end
    step = 1'b0;
    checks++;
    if (!fell_a || !fell_b) begin
      errors++;
      $display("FAIL reset_never_fell: a=%0d b=%0d expected 1 1", fell_a, fell_b);
    end
  endtask

  // Random run toggles, step pulses and rare ereset_n pulses.
  task automatic test_run_halt_random();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) run = ~run;
      step     = ($urandom_range(0, 7) == 0);
      ereset_n = ($urandom_range(0, 1999) != 0);
      tick();
      checks++;
      if (obs_a !== exp_out(0)) begin
        errors++;
        $display("FAIL random_a step %0d: got %b expected %b", i, obs_a, exp_out(0));
      end
      checks++;
      if (obs_b !== exp_out(1)) begin
        errors++;
        $display("FAIL random_b step %0d: got %b expected %b", i, obs_b, exp_out(1));
      end
    end
    ereset_n = 1'b1;
    step     = 1'b0;
    run      = 1'b1;
  endtask

`ifdef CLOCKS_4004_STEP_EN
  // Drop run mid-period, then single-step one period.
  task automatic test_single_step();
    int n = 0;
    int c1 = 0;
    int c2 = 0;
    logic [2:0] sc0;
    run = 1'b1; step = 1'b0; ereset_n = 1'b1;
    while ((m_inrst[0] || m_halt[0] || reset_a !== 1'b0 || (m_n[0] % 20) != 5) && n < 1000) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL step_setup_timeout: waited %0d cycles expected < 1000", n);
    end
    run = 1'b0;
    n = 0;
    while (halted_a !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (halted_a !== 1'b1 || obs_a[7:4] !== 4'b0000) begin
      errors++;
      $display("FAIL halt_entry: got %b after %0d cycles expected 0000xxx1", obs_a, n);
    end
    sc0 = subcyc_a;
    step = 1'b1;
    tick();
    step = 1'b0;
    checks++;
    if (clk1_a !== 1'b1 || halted_a !== 1'b0) begin
      errors++;
      $display("FAIL step_first_cycle: clk1=%b halted=%b expected 1 0", clk1_a, halted_a);
    end
    c1 = (clk1_a === 1'b1) ? 1 : 0;
    repeat (19) begin
      step = ($urandom_range(0, 3) == 0);
      tick();
      c1 += (clk1_a === 1'b1) ? 1 : 0;
      c2 += (clk2_a === 1'b1) ? 1 : 0;
    end
    step = 1'b0;
    checks++;
    if (halted_a !== 1'b0) begin
      errors++;
      $display("FAIL step_early_halt: halted=%b expected 0", halted_a);
    end
    tick();
    checks++;
    if (halted_a !== 1'b1 || clk1_a !== 1'b0 || clk2_a !== 1'b0) begin
      errors++;
      $display("FAIL step_end: got %b expected halted with phases low", obs_a);
    end
    checks++;
    if (c1 != 6 || c2 != 6) begin
      errors++;
      $display("FAIL step_pulses: clk1 cycles %0d clk2 cycles %0d expected 6 6", c1, c2);
    end
    checks++;
    if (subcyc_a !== 3'(sc0 + 3'd1)) begin
      errors++;
      $display("FAIL step_subcyc: got %0d expected %0d", subcyc_a, 3'(sc0 + 3'd1));
    end
    run = 1'b1;
    tick();
  endtask
`else
  // Without step control, run low must not halt the generator.
  task automatic test_inputs_ignored();
    int n = 0;
    int c1 = 0;
    int h = 0;
    run = 1'b1; step = 1'b0; ereset_n = 1'b1;
    while (reset_a !== 1'b0 && n < 1000) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL ignored_setup_timeout: waited %0d cycles expected < 1000", n);
    end
    run = 1'b0;
    repeat (60) begin
      step = ($urandom_range(0, 3) == 0);
      tick();
      c1 += (clk1_a === 1'b1) ? 1 : 0;
      h  += (halted_a !== 1'b0) ? 1 : 0;
    end
    step = 1'b0;
    run  = 1'b1;
    checks++;
    if (c1 != 18 || h != 0) begin
      errors++;
      $display("FAIL inputs_ignored: clk1 cycles %0d halted cycles %0d expected 18 0", c1, h);
    end
  endtask
`endif

  // ereset_n asserted while clk2 is high at p = 10, then a full reset hold.
  task automatic test_mid_reset();
    int n = 0;
    run = 1'b1; step = 1'b0; ereset_n = 1'b1;
    while ((m_inrst[0] || m_halt[0] || (m_n[0] % 20) != 10) && n < 500) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 500 || clk2_a !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_setup: clk2=%b after %0d cycles expected 1", clk2_a, n);
    end
    ereset_n = 1'b0;
    tick();
    checks++;
    if (obs_a !== 8'b1000_0000) begin
      errors++;
      $display("FAIL mid_reset_entry: got %b expected %b", obs_a, 8'b1000_0000);
    end
    ereset_n = 1'b1;
    tick();
    checks++;
    if (obs_a !== 8'b1101_0000) begin
      errors++;
      $display("FAIL mid_reset_release: got %b expected %b", obs_a, 8'b1101_0000);
    end
    n = 0;
    while (reset_a === 1'b1 && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (n != 320) begin
      errors++;
      $display("FAIL mid_reset_hold: reset fell after %0d cycles expected 320", n);
    end
    checks++;
    if (subcyc_a !== 3'd0 || ps_a !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_subcyc: subcyc=%0d period_start=%b expected 0 1", subcyc_a, ps_a);
    end
  endtask

  initial begin
    ereset_n = 1'b0;
    run      = 1'b1;
    step     = 1'b0;
    test_reset();
    test_free_run();
    test_run_halt_random();
`ifdef CLOCKS_4004_STEP_EN
    test_single_step();
`else
    test_inputs_ignored();
`endif
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
